// File: rtl/score_uart_reporter.sv
// Prints one ASCII status line of all player scores over an 8N1 UART per score event burst,
// with an optional winner tag and coalescing of events that arrive while a line is in flight.
module score_uart_reporter #(
   parameter int CLK_FREQ    = 100000000,
   parameter int BAUD        = 115200,
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 3,
   parameter int WIN_SCORE   = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   input  logic [NUM_PLAYERS-1:0]         scored,
   output logic                           uart_tx,
   output logic                           busy,
   output logic                           overrun
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int FIELDS_END   = 6 * NUM_PLAYERS - 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                         state;
   logic [BAUD_W-1:0]              baud_cnt;
   logic [2:0]                     bit_idx;
   logic [5:0]                     char_idx;
   logic [NUM_PLAYERS*SCORE_W-1:0] snap;
   logic                           pending;
   logic                           trig_q;
   logic                           trigger;
   logic                           has_win;
   int                             win_idx;
   logic [5:0]                     last_idx;
   logic [7:0]                     cur_char;

   assign trigger = |scored;

   // Lowest-index player at or above the threshold; the descending loop lets lower indices win.
   always_comb begin
      has_win = 1'b0;
      win_idx = 0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (WIN_SCORE != 0 && int'(snap[i*SCORE_W +: SCORE_W]) >= WIN_SCORE) begin
            has_win = 1'b1;
            win_idx = i;
         end
      end
      last_idx = has_win ? 6'(FIELDS_END + 4) : 6'(FIELDS_END + 1);
   end

   // Character at char_idx: six-character slots per player, then the optional tag and CR LF.
   always_comb begin
      int idx, p, k, v, off;
      idx      = int'(char_idx);
      p        = idx / 6;
      k        = idx % 6;
      off      = idx - FIELDS_END;
      v        = 0;
      cur_char = 8'h0A;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (i == p) v = int'(snap[i*SCORE_W +: SCORE_W]);
      end
      if (v > 99) v = 99;
      if (idx < FIELDS_END) begin
         case (k)
            0:       cur_char = 8'h50;
            1:       cur_char = 8'(p + 49);
            2:       cur_char = 8'h3A;
            3:       cur_char = 8'(v / 10 + 48);
            4:       cur_char = 8'(v % 10 + 48);
            default: cur_char = 8'h20;
         endcase
      end else if (has_win) begin
         case (off)
            0:       cur_char = 8'h20;
            1:       cur_char = 8'h57;
            2:       cur_char = 8'(win_idx + 49);
            3:       cur_char = 8'h0D;
            default: cur_char = 8'h0A;
         endcase
      end else begin
         cur_char = (off == 0) ? 8'h0D : 8'h0A;
      end
   end

   // Snapshot is taken on the trigger edge; trig_q delays the start bit by one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         pending  <= 1'b0;
         trig_q   <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         char_idx <= '0;
         snap     <= '0;
      end else begin
         if (trigger && (state != IDLE || trig_q)) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (trig_q) begin
                  trig_q   <= 1'b0;
                  state    <= START;
                  uart_tx  <= 1'b0;
                  busy     <= 1'b1;
                  baud_cnt <= '0;
                  char_idx <= '0;
               end else if (trigger) begin
                  snap   <= scores;
                  trig_q <= 1'b1;
               end
            end
            START: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  uart_tx  <= cur_char[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= cur_char[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (char_idx != last_idx) begin
                     char_idx <= char_idx + 6'd1;
                     state    <= START;
                     uart_tx  <= 1'b0;
                  end else if (pending || trigger) begin
                     // A trigger landing on the final edge still counts as coalesced.
                     pending  <= pending && trigger;
                     snap     <= scores;
                     char_idx <= '0;
                     state    <= START;
                     uart_tx  <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/score_uart_reporter.md
Name: score_uart_reporter

Overview:
- Parametrised successor to the two-player UART score printer.
- Supports NUM_PLAYERS score channels, configurable baud, and zero-padded decimal fields.
- Appends a winner tag and coalesces score events that arrive while a line is in flight.
- Sits beside the game logic. It takes the packed score bus and per-player scored pulses, and drives the board `uart_tx` pin with one ASCII status line per event burst.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be ≥ 2).
- NUM_PLAYERS, 2, number of score channels, legal range 1..9.
- SCORE_W, 3, bits per score, legal range 1..7.
- WIN_SCORE, 5, winning threshold. 0 disables the winner tag.

Ports:
- clk  in  1  system clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- scores  in  NUM_PLAYERS*SCORE_W  packed unsigned scores. Player i (0-based) occupies bits [i*SCORE_W +: SCORE_W].
- scored  in  NUM_PLAYERS  one-cycle pulse per player. Any set bit is a trigger.
- uart_tx  out  1  8N1 serial output, LSB first, idle high.
- busy  out  1  high from the first start bit to the end of the last stop bit of a line.
- overrun  out  1  sticky. Set when a trigger arrives while a re-send is already pending. Cleared only by rst.

Behaviour:
- Reset values: uart_tx=1, busy=0, overrun=0, pending=0, state=IDLE, all counters=0.
- rst asserted mid-frame aborts immediately. uart_tx returns high on the next edge and no partial character resumes.
- Trigger: |scored sampled at edge t.
  - If state is IDLE, the scores are snapshotted at edge t.
  - The start bit of the first character is driven at edge t+1, and busy=1 from t+1.
- Snapshot scope: the snapshot is held for the whole line. Score changes during transmission do not alter the line in flight.
- Coalescing: a trigger while busy sets pending.
  - A trigger while pending is already set sets overrun; pending stays 1.
  - Simultaneous pulses on several players count as one trigger.
- End of line: after the last stop bit, if pending is set, pending clears, a fresh snapshot is taken, and the next line's start bit begins on the following edge with busy held high. Otherwise the block returns to IDLE and busy=0.
- Line format for N=NUM_PLAYERS:
  - For each player i=1..N: 'P', ASCII digit i, ':', tens digit, units digit.
  - Fields are separated by a single ' ' (0x20).
  - If WIN_SCORE≠0 and any snapshot score ≥ WIN_SCORE, append ' ','W', then the ASCII digit of the lowest-index such player.
  - Terminate with 0x0D, 0x0A.
  - Length is 6N+1 characters, or 6N+4 with the winner tag.
- Decimal rules:
  - Two digits, zero-padded.
  - Values > 99 (possible only with SCORE_W=7) print as "99".
- Bit timing:
  - Each bit (start=0, d0..d7, stop=1) holds for exactly CLKS_PER_BIT cycles.
  - Consecutive characters are back-to-back with no idle gap.
  - One character therefore takes 10*CLKS_PER_BIT cycles.
- FSM:
  - IDLE → START on trigger.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if characters remain or pending is set.
  - STOP → IDLE otherwise.
- Counters:
  - The baud counter wraps at CLKS_PER_BIT-1.
  - The bit index runs 0..7.
  - The char index is reset at each line start and is sized for 6*9+4 characters.

Test Plan:
- Idle/reset (CLK_FREQ=16, BAUD=1, N=2, WIN_SCORE=5): hold rst for 3 cycles, release with no pulses for 500 cycles → uart_tx=1, busy=0, overrun=0 throughout.
- Basic line: scores P1=3, P2=1, pulse scored=2'b01 at edge t → uart_tx low at t+1. Decoded bytes are "P1:03 P2:01\r\n" (13 bytes), busy falls after exactly 13*160 cycles.
- Winner tag: P1=2, P2=5, pulse scored[1] → "P1:02 P2:05 W2\r\n" (16 bytes). With P1=5, P2=6 the tag is " W1".
- Coalescing: pulse, then two further pulses during the first line → exactly two lines transmitted back-to-back with no gap. The second line reflects the scores at the end of the first line, and overrun=1 after the third pulse.
- Simultaneous/reset: scored=2'b11 in one cycle → one line only. Asserting rst during bit 4 of character 3 → uart_tx=1 next edge, busy=0, no further bytes.
- Width sweep: N=9, SCORE_W=7, player 9 score 120 → field "P9:99". Line length is 55 bytes, or 58 if a winner is present.
